// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port arbiter in front of a single-port 8-bit-address / 16-bit-data memory
//
// Purpose: shares one memory port between the CPU MAR/MDR port and a DMA/loader port.
// The winning request is registered onto mem_*, read latency is counted down, and the
// result is returned to the owner with a one-cycle ack pulse.
//
// Ports:
//   clk, reset                        clock (rising edge), synchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_ack  CPU request, held until cpu_ack; cpu_rdata holds last read
//   dma_req/we/addr/wdata -> dma_ack  DMA request, same protocol; dma_rdata holds last read
//   mem_en/we/addr/wdata, mem_rdata   memory bus; mem_rdata valid RD_LAT cycles after mem_en
//   busy                              high whenever a transaction is in flight
//   gnt_dma                           owner of the current/last transaction (1 = DMA)
module mem_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int RD_LAT       = 1,
    parameter int CPU_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              gnt_dma
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] ACK     = 2'd3;

    logic [1:0] state;
    logic [2:0] wait_cnt;
    logic       last_gnt;   // 1 = DMA owned the previous grant
    logic       pick_dma;

    // On a tie, round-robin hands the bus to whichever port did not win last time.
    always_comb begin
        pick_dma = dma_req;
        if (cpu_req && dma_req) begin
            if (CPU_PRIORITY != 0) begin
                pick_dma = 1'b0;
            end else begin
                pick_dma = ~last_gnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            last_gnt  <= 1'b1;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            gnt_dma   <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        gnt_dma   <= pick_dma;
                        last_gnt  <= pick_dma;
                        mem_en    <= 1'b1;
                        mem_we    <= pick_dma ? dma_we    : cpu_we;
                        mem_addr  <= pick_dma ? dma_addr  : cpu_addr;
                        mem_wdata <= pick_dma ? dma_wdata : cpu_wdata;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    if (mem_we) begin
                        // Writes complete as soon as the strobe has been seen.
                        if (gnt_dma) begin
                            dma_ack <= 1'b1;
                        end else begin
                            cpu_ack <= 1'b1;
                        end
                        state <= ACK;
                    end else begin
                        wait_cnt <= 3'(RD_LAT - 1);
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else begin
                        // mem_rdata is valid this cycle; ack rises with the captured data.
                        if (gnt_dma) begin
                            dma_rdata <= mem_rdata;
                            dma_ack   <= 1'b1;
                        end else begin
                            cpu_rdata <= mem_rdata;
                            cpu_ack   <= 1'b1;
                        end
                        state <= ACK;
                    end
                end
                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_en <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst;
    logic [1:0] cpu_req, cpu_we, cpu_ack, dma_req, dma_we, dma_ack;
    logic [1:0] mem_en, mem_we, busy, gnt_dma;
    logic [1:0][7:0]  cpu_addr, dma_addr, mem_addr;
    logic [1:0][15:0] cpu_wdata, cpu_rdata, dma_wdata, dma_rdata, mem_wdata, mem_rdata;

    int tests = 0;
    int failed = 0;

    // Reference model state: expected memory contents and the arbiter's "last winner".
    logic [15:0] exp_mem [2][256];
    bit          lastg [2];

    function automatic logic [15:0] init_val(input logic [7:0] a);
        if (a == 8'h05) return 16'h1234;
        if (a == 8'h20) return 16'h00AA;
        return {a ^ 8'hC3, ~a};
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit pri(input int d);
        return (d == 0) ? 1'b0 : 1'b1;
    endfunction

    // Instance 0: RD_LAT=1 round-robin; instance 1: RD_LAT=3 CPU priority.
    for (genvar i = 0; i < 2; i++) begin : g
        localparam int RL = (i == 0) ? 1 : 3;
        localparam int PR = (i == 0) ? 0 : 1;

        mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(RL), .CPU_PRIORITY(PR)) dut (
            .clk(clk), .reset(rst[i]),
            .cpu_req(cpu_req[i]), .cpu_we(cpu_we[i]), .cpu_addr(cpu_addr[i]),
            .cpu_wdata(cpu_wdata[i]), .cpu_ack(cpu_ack[i]), .cpu_rdata(cpu_rdata[i]),
            .dma_req(dma_req[i]), .dma_we(dma_we[i]), .dma_addr(dma_addr[i]),
            .dma_wdata(dma_wdata[i]), .dma_ack(dma_ack[i]), .dma_rdata(dma_rdata[i]),
            .mem_en(mem_en[i]), .mem_we(mem_we[i]), .mem_addr(mem_addr[i]),
            .mem_wdata(mem_wdata[i]), .mem_rdata(mem_rdata[i]),
            .busy(busy[i]), .gnt_dma(gnt_dma[i])
        );

        // Memory: data appears RL cycles after the address cycle.
        logic [15:0]  mem [256];
        logic [255:0] written = '0;
        logic [15:0]  pipe [RL];
        always @(posedge clk) begin
            if (mem_en[i] && mem_we[i]) begin
                mem[mem_addr[i]]     <= mem_wdata[i];
                written[mem_addr[i]] <= 1'b1;
            end
            pipe[0] <= written[mem_addr[i]] ? mem[mem_addr[i]] : init_val(mem_addr[i]);
            for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata[i] = pipe[RL-1];
    end

    task automatic drive(input int d, input int q, input bit r, input bit we,
                         input logic [7:0] a, input logic [15:0] w);
        if (q != 0) begin
            dma_req[d] = r; dma_we[d] = we; dma_addr[d] = a; dma_wdata[d] = w;
        end else begin
            cpu_req[d] = r; cpu_we[d] = we; cpu_addr[d] = a; cpu_wdata[d] = w;
        end
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        drive(d, 0, 0, 0, 8'h00, 16'h0000);
        drive(d, 1, 0, 0, 8'h00, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst[d] = 1'b0;
        lastg[d] = 1'b1;
    endtask

    // One isolated transaction; cycle 0 is the IDLE cycle in which req is first sampled.
    task automatic xact(input int d, input bit p, input bit we, input logic [7:0] a,
                        input logic [15:0] wd, input bit drop, input string nm);
        int ack_c, en_n, en_c;
        bit fields_ok, busy_ok, stray;
        logic [15:0] own0, oth0, got, exp_d;
        int exp_c;
        exp_c = we ? 2 : 2 + lat(d);
        @(posedge clk);
        #1;
        own0 = p ? dma_rdata[d] : cpu_rdata[d];
        oth0 = p ? cpu_rdata[d] : dma_rdata[d];
        drive(d, p, 1, we, a, wd);
        ack_c = -1; en_n = 0; en_c = -1; fields_ok = 1; busy_ok = 1; stray = 0; got = '0;
        for (int c = 0; c <= 20 && ack_c < 0; c++) begin
            @(negedge clk);
            if (mem_en[d]) begin
                en_n++; en_c = c;
                if (mem_we[d] !== we || mem_addr[d] !== a || (we && mem_wdata[d] !== wd)) fields_ok = 0;
            end
            if (c == 0 && busy[d] !== 1'b0) busy_ok = 0;
            if (c >= 1 && (busy[d] !== 1'b1 || gnt_dma[d] !== p)) busy_ok = 0;
            if ((p ? cpu_ack[d] : dma_ack[d]) !== 1'b0) stray = 1;
            if ((p ? dma_ack[d] : cpu_ack[d]) === 1'b1) begin
                ack_c = c;
                got = p ? dma_rdata[d] : cpu_rdata[d];
                drive(d, p, 0, we, a, wd);
            end else if (c == 1 && drop) begin
                // Dropped req and scrambled fields must not disturb the latched transaction.
                drive(d, p, 0, ~we, ~a, ~wd);
            end
        end
        exp_d = we ? own0 : exp_mem[d][a];
        tests++;
        if (en_n !== 1 || en_c !== 1 || !fields_ok)
            begin failed++; $display("FAIL %s d%0d mem_en count %0d cycle %0d fields_ok %0d, want 1/1/1", nm, d, en_n, en_c, fields_ok); end
        tests++;
        if (ack_c !== exp_c)
            begin failed++; $display("FAIL %s d%0d ack cycle %0d, want %0d", nm, d, ack_c, exp_c); end
        tests++;
        if (got !== exp_d)
            begin failed++; $display("FAIL %s d%0d owner rdata %h, want %h", nm, d, got, exp_d); end
        tests++;
        if (stray || !busy_ok || (p ? cpu_rdata[d] : dma_rdata[d]) !== oth0)
            begin failed++; $display("FAIL %s d%0d stray_ack %0d busy_gnt_ok %0d other rdata %h, want 0/1/%h", nm, d, stray, busy_ok, p ? cpu_rdata[d] : dma_rdata[d], oth0); end
        if (we) exp_mem[d][a] = wd;
        lastg[d] = p;
    endtask

    task automatic test_reset;
        for (int d = 0; d < 2; d++) begin
            do_reset(d);
            @(negedge clk);
            tests++;
            if ({cpu_ack[d], cpu_rdata[d], dma_ack[d], dma_rdata[d], mem_en[d], mem_we[d],
                 mem_addr[d], mem_wdata[d], busy[d], gnt_dma[d]} !== '0)
                begin failed++; $display("FAIL reset d%0d outputs not all zero busy=%b mem_en=%b gnt=%b", d, busy[d], mem_en[d], gnt_dma[d]); end
        end
    endtask

    task automatic test_cpu_read;
        xact(0, 0, 0, 8'h05, 16'h0000, 0, "cpu_read");
        tests++;
        if (cpu_rdata[0] !== 16'h1234)
            begin failed++; $display("FAIL cpu_read value %h, want 1234", cpu_rdata[0]); end
    endtask

    task automatic test_dma_write;
        xact(0, 1, 1, 8'h10, 16'hBEEF, 0, "dma_write");
        xact(0, 0, 0, 8'h10, 16'h0000, 0, "dma_write_readback");
        tests++;
        if (cpu_rdata[0] !== 16'hBEEF)
            begin failed++; $display("FAIL dma_write readback %h, want beef", cpu_rdata[0]); end
    endtask

    task automatic test_read_then_write;
        xact(0, 0, 0, 8'h20, 16'h0000, 0, "rtw_read");
        xact(0, 0, 1, 8'h31, 16'h5A5A, 0, "rtw_write");
        tests++;
        if (cpu_rdata[0] !== 16'h00AA)
            begin failed++; $display("FAIL rtw cpu_rdata %h, want 00aa", cpu_rdata[0]); end
    endtask

    // Both requests held continuously; every grant order comes from the arbitration rule.
    task automatic test_contention(input int d, input int n, input string nm);
        logic [7:0]  a [2];
        logic [15:0] w [2];
        bit          wq [2];
        int grants, en_n;
        bit p, exp_p, both;
        logic [15:0] got;
        do_reset(d);
        @(posedge clk);
        #1;
        for (int q = 0; q < 2; q++) begin
            wq[q] = 1'($urandom_range(0, 1)); a[q] = 8'($urandom); w[q] = 16'($urandom);
            drive(d, q, 1, wq[q], a[q], w[q]);
        end
        grants = 0; en_n = 0; both = 0;
        for (int cyc = 0; cyc < 200 && grants < n; cyc++) begin
            @(negedge clk);
            if (mem_en[d]) en_n++;
            if (cpu_ack[d] && dma_ack[d]) both = 1;
            if (cpu_ack[d] || dma_ack[d]) begin
                p = dma_ack[d];
                exp_p = pri(d) ? 1'b0 : ~lastg[d];
                lastg[d] = exp_p;
                tests++;
                if (p !== exp_p)
                    begin failed++; $display("FAIL %s grant %0d owner %0d, want %0d", nm, grants, p, exp_p); end
                got = p ? dma_rdata[d] : cpu_rdata[d];
                if (!wq[p]) begin
                    tests++;
                    if (got !== exp_mem[d][a[p]])
                        begin failed++; $display("FAIL %s grant %0d rdata %h, want %h", nm, grants, got, exp_mem[d][a[p]]); end
                end else begin
                    exp_mem[d][a[p]] = w[p];
                end
                wq[p] = 1'($urandom_range(0, 1)); a[p] = 8'($urandom); w[p] = 16'($urandom);
                drive(d, p, 1, wq[p], a[p], w[p]);
                grants++;
            end
        end
        tests++;
        if (grants !== n || en_n !== grants || both)
            begin failed++; $display("FAIL %s grants %0d mem_en %0d double_ack %0d, want %0d/%0d/0", nm, grants, en_n, both, n, n); end
        drive(d, 0, 0, 0, 8'h00, 16'h0000);
        drive(d, 1, 0, 0, 8'h00, 16'h0000);
        repeat (8) @(posedge clk);
    endtask

    task automatic test_reset_abort;
        bit bad;
        do_reset(1);
        @(posedge clk); #1; drive(1, 0, 1, 0, 8'h05, 16'h0000);
        @(posedge clk); #1;
        @(posedge clk); #1; rst[1] = 1'b1; drive(1, 0, 0, 0, 8'h00, 16'h0000);
        @(negedge clk);
        tests++;
        if (busy[1] !== 1'b1)
            begin failed++; $display("FAIL abort busy in rd_wait %b, want 1", busy[1]); end
        @(posedge clk); #1; rst[1] = 1'b0; lastg[1] = 1'b1;
        @(negedge clk);
        tests++;
        if ({busy[1], mem_en[1], cpu_ack[1], dma_ack[1]} !== 4'b0000 || cpu_rdata[1] !== 16'h0000)
            begin failed++; $display("FAIL abort after reset busy/en/acks %b rdata %h, want 0000/0000", {busy[1], mem_en[1], cpu_ack[1], dma_ack[1]}, cpu_rdata[1]); end
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_ack[1] || dma_ack[1] || mem_en[1]) bad = 1;
        end
        tests++;
        if (bad)
            begin failed++; $display("FAIL abort late activity seen %0d, want 0", bad); end
        xact(1, 1, 0, 8'h20, 16'h0000, 0, "abort_dma_read");
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            xact(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 256; k++) exp_mem[d][k] = init_val(8'(k));
            lastg[d] = 1'b1;
        end
        rst = 2'b11;
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_read_then_write();
        test_contention(0, 4, "round_robin");
        test_contention(1, 4, "cpu_priority");
        test_reset_abort();
        test_random(40);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
